reg_alu_pipe: RTL and testbench

REG_ALU_PIPE -- requirements
Module: reg_alu_pipe

---
 rtl/reg_alu_pipe_pkg.sv | 38 +++
 rtl/reg_alu_pipe_if.sv | 33 +++
 rtl/regfile_param.sv | 34 +++
 rtl/reg_alu_pipe.sv | 209 ++++++++++++++++++++
 tb/tb_reg_alu_pipe.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/reg_alu_pipe_pkg.sv
// rtl/reg_alu_pipe_pkg.sv - shared opcodes, writeback selects, PSR bit indices and FSM states
package reg_alu_pipe_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_CMP = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_LSH = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_PC   = 2'd2;
  localparam logic [1:0] WB_NONE = 2'd3;

  localparam int PSR_C = 0;
  localparam int PSR_L = 1;
  localparam int PSR_F = 2;
  localparam int PSR_Z = 3;
  localparam int PSR_N = 4;
  localparam int PSR_W = 5;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_MUL = 1'b1
  } state_t;

  // Undefined opcodes, and MUL when the multiplier is not built, behave as MOV.
  function automatic logic [3:0] decode_op(input logic [3:0] op, input logic mul_en);
    if (op == OP_MUL) return mul_en ? OP_MUL : OP_MOV;
    if (op > OP_MUL) return OP_MOV;
    return op;
  endfunction

endpackage

// File: rtl/reg_alu_pipe_if.sv
// rtl/reg_alu_pipe_if.sv - instruction, operand read-back and writeback signals of reg_alu_pipe
// master: instruction source (valid_in, rSrc, rDst, aluOp, imm_sel, imm, wb_sel, pc, mem_data)
// slave : pipeline (ready_out, dSrc, dDst, psr_out, wb_valid, wb_data)
interface reg_alu_pipe_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
);
  logic              valid_in;
  logic              ready_out;
  logic [REG_AW-1:0] rSrc;
  logic [REG_AW-1:0] rDst;
  logic [3:0]        aluOp;
  logic              imm_sel;
  logic [DATA_W-1:0] imm;
  logic [1:0]        wb_sel;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] dSrc;
  logic [DATA_W-1:0] dDst;
  logic [4:0]        psr_out;
  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output valid_in, rSrc, rDst, aluOp, imm_sel, imm, wb_sel, pc, mem_data,
    input  ready_out, dSrc, dDst, psr_out, wb_valid, wb_data
  );

  modport slave (
    input  valid_in, rSrc, rDst, aluOp, imm_sel, imm, wb_sel, pc, mem_data,
    output ready_out, dSrc, dDst, psr_out, wb_valid, wb_data
  );
endinterface

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - REG_CNT x DATA_W register file, two combinational reads, one write
// clk, reset : clock, asynchronous active-high clear of every register
// we, wa, wd : synchronous write enable, address, data
// ra0/rd0, ra1/rd1 : combinational read ports
module regfile_param #(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 16,
  parameter int REG_AW  = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [REG_AW-1:0] ra0,
  input  logic [REG_AW-1:0] ra1,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1
);

  logic [DATA_W-1:0] mem [REG_CNT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_CNT; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];

endmodule

// File: rtl/reg_alu_pipe.sv
// rtl/reg_alu_pipe.sv - accept/EX/writeback ALU pipeline with bypass and shift-add multiplier
// clk, reset : clock, asynchronous active-high reset
// bus        : slave side of reg_alu_pipe_if (instruction in, operands/flags/writeback out)
module reg_alu_pipe
  import reg_alu_pipe_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 16,
  parameter int REG_AW  = $clog2(REG_CNT),
  parameter int MUL_EN  = 1
) (
  input logic         clk,
  input logic         reset,
  reg_alu_pipe_if.slave bus
);

  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_t            state;
  logic              ready_q;

  logic              ex_valid;
  logic [REG_AW-1:0] ex_rd;
  logic [3:0]        ex_op;
  logic [1:0]        ex_wb_sel;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [DATA_W-1:0] ex_pc;
  logic [DATA_W-1:0] ex_mem;

  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] mul_b;
  logic [DATA_W-1:0] mul_acc;
  logic [DATA_W-1:0] mul_acc_nxt;
  logic [CNT_W-1:0]  mul_cnt;

  logic [PSR_W-1:0]  psr_q;
  logic [PSR_W-1:0]  psr_next;
  logic              wb_valid_q;
  logic [DATA_W-1:0] wb_data_q;

  logic [DATA_W-1:0] rf_src;
  logic [DATA_W-1:0] rf_dst;
  logic [DATA_W-1:0] d_src;
  logic [DATA_W-1:0] d_dst;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] ex_data;
  logic [DATA_W:0]   sum_ext;
  logic [DATA_W:0]   dif_ext;
  logic [DATA_W-1:0] neg_b;
  logic [3:0]        acc_op;
  logic              accept;
  logic              ex_we;

  // CMP never writes; wb_sel NONE suppresses the write but not the flag update.
  assign ex_we  = ex_valid && (ex_wb_sel != WB_NONE) && (ex_op != OP_CMP);
  assign accept = bus.valid_in && ready_q;
  assign acc_op = decode_op(bus.aluOp, MUL_EN != 0);

  regfile_param #(
    .DATA_W (DATA_W),
    .REG_CNT(REG_CNT),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk  (clk),
    .reset(reset),
    .we   (ex_we),
    .wa   (ex_rd),
    .wd   (ex_data),
    .ra0  (bus.rSrc),
    .ra1  (bus.rDst),
    .rd0  (rf_src),
    .rd1  (rf_dst)
  );

  // The EX result is written on the coming edge; bypass it so a dependent
  // instruction presented now reads the new value without a bubble.
  assign d_src = (ex_we && (ex_rd == bus.rSrc)) ? ex_data : rf_src;
  assign d_dst = (ex_we && (ex_rd == bus.rDst)) ? ex_data : rf_dst;
  assign op_a  = d_dst;
  assign op_b  = bus.imm_sel ? bus.imm : d_src;

  assign mul_acc_nxt = mul_acc + (mul_b[0] ? mul_a : '0);

  always_comb begin
    sum_ext  = {1'b0, ex_a} + {1'b0, ex_b};
    dif_ext  = {1'b0, ex_a} - {1'b0, ex_b};
    neg_b    = '0 - ex_b;
    alu_res  = ex_b;
    psr_next = psr_q;
    case (ex_op)
      OP_ADD: begin
        alu_res         = sum_ext[DATA_W-1:0];
        psr_next[PSR_C] = sum_ext[DATA_W];
        psr_next[PSR_F] = (ex_a[DATA_W-1] == ex_b[DATA_W-1]) &&
                          (sum_ext[DATA_W-1] != ex_a[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res         = dif_ext[DATA_W-1:0];
        psr_next[PSR_C] = dif_ext[DATA_W];
        psr_next[PSR_F] = (ex_a[DATA_W-1] != ex_b[DATA_W-1]) &&
                          (dif_ext[DATA_W-1] != ex_a[DATA_W-1]);
      end
      OP_CMP: begin
        alu_res         = ex_a;
        psr_next[PSR_Z] = (ex_a == ex_b);
        psr_next[PSR_L] = (ex_b < ex_a);
        psr_next[PSR_N] = ($signed(ex_b) < $signed(ex_a));
      end
      OP_AND: alu_res = ex_a & ex_b;
      OP_OR:  alu_res = ex_a | ex_b;
      OP_XOR: alu_res = ex_a ^ ex_b;
      // Negative B shifts right by its magnitude (low 4 bits only).
      OP_LSH: alu_res = ex_b[DATA_W-1] ? (ex_a >> neg_b[3:0]) : (ex_a << ex_b[3:0]);
      default: alu_res = ex_b;
    endcase
  end

  always_comb begin
    case (ex_wb_sel)
      WB_MEM:  ex_data = ex_mem;
      WB_PC:   ex_data = ex_pc;
      default: ex_data = alu_res;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      ready_q   <= 1'b1;
      ex_valid  <= 1'b0;
      ex_rd     <= '0;
      ex_op     <= OP_MOV;
      ex_wb_sel <= WB_NONE;
      ex_a      <= '0;
      ex_b      <= '0;
      ex_pc     <= '0;
      ex_mem    <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_acc   <= '0;
      mul_cnt   <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          ex_valid <= 1'b0;
          if (accept) begin
            ex_rd     <= bus.rDst;
            ex_wb_sel <= bus.wb_sel;
            ex_a      <= op_a;
            ex_b      <= op_b;
            ex_pc     <= bus.pc;
            ex_mem    <= bus.mem_data;
            if (acc_op == OP_MUL) begin
              state   <= ST_MUL;
              ready_q <= 1'b0;
              mul_a   <= op_a;
              mul_b   <= op_b;
              mul_acc <= '0;
              mul_cnt <= '0;
            end else begin
              ex_valid <= 1'b1;
              ex_op    <= acc_op;
            end
          end
        end
        ST_MUL: begin
          mul_acc <= mul_acc_nxt;
          mul_a   <= mul_a << 1;
          mul_b   <= mul_b >> 1;
          mul_cnt <= mul_cnt + CNT_W'(1);
          // Product re-enters EX as a MOV so it takes the normal writeback
          // and bypass path; MOV leaves every flag untouched.
          if (mul_cnt == CNT_LAST) begin
            state    <= ST_RUN;
            ready_q  <= 1'b1;
            ex_valid <= 1'b1;
            ex_op    <= OP_MOV;
            ex_b     <= mul_acc_nxt;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psr_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= ex_we;
      if (ex_valid) psr_q <= psr_next;
      if (ex_we) wb_data_q <= ex_data;
    end
  end

  assign bus.ready_out = ready_q;
  assign bus.dSrc      = d_src;
  assign bus.dDst      = d_dst;
  assign bus.psr_out   = psr_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_data   = wb_data_q;

endmodule

// File: tb/tb_reg_alu_pipe.sv
// tb/tb_reg_alu_pipe.sv - directed self-checking bench for reg_alu_pipe
module tb_reg_alu_pipe;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_CMP = 4'd2;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_LSH = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_PC   = 2'd2;
  localparam logic [1:0] WB_NONE = 2'd3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  reg_alu_pipe_if #(.DATA_W(16), .REG_AW(4)) bus ();

  reg_alu_pipe #(.DATA_W(16), .REG_CNT(16), .MUL_EN(1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] dst, input logic [3:0] src,
                       input logic isel, input logic [15:0] immv, input logic [1:0] wsel);
    bus.aluOp    = op;
    bus.rDst     = dst;
    bus.rSrc     = src;
    bus.imm_sel  = isel;
    bus.imm      = immv;
    bus.wb_sel   = wsel;
    bus.valid_in = 1'b1;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.valid_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [3:0] addr, input logic [15:0] exp);
    bus.rSrc = addr;
    #1;
    check(tag, bus.dSrc, exp);
  endtask

  int low_cnt;
  int pulses;
  int first_wb;

  initial begin
    bus.valid_in = 1'b0;
    bus.rSrc     = '0;
    bus.rDst     = '0;
    bus.aluOp    = OP_MOV;
    bus.imm_sel  = 1'b0;
    bus.imm      = '0;
    bus.wb_sel   = WB_ALU;
    bus.pc       = '0;
    bus.mem_data = '0;

    #12;
    check("rst_ready", bus.ready_out, 1);
    check("rst_psr", bus.psr_out, 0);
    check("rst_wb_valid", bus.wb_valid, 0);
    check("rst_wb_data", bus.wb_data, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Bypass: r2=3, r1=5, then ADD r2=r2+r1 with r1 still in EX
    issue(OP_MOV, 4'd2, 4'd0, 1'b1, 16'd3, WB_ALU); tick();
    issue(OP_MOV, 4'd1, 4'd0, 1'b1, 16'd5, WB_ALU); tick();
    issue(OP_ADD, 4'd2, 4'd1, 1'b0, 16'd0, WB_ALU);
    check("byp_ready", bus.ready_out, 1);
    check("byp_dsrc", bus.dSrc, 16'd5);
    check("byp_ddst", bus.dDst, 16'd3);
    tick();
    idle(1);
    check("add_wb_valid", bus.wb_valid, 1);
    check("add_wb_data", bus.wb_data, 16'd8);
    rd("add_r2", 4'd2, 16'd8);
    check("add_psr", bus.psr_out, 5'h00);

    // Signed overflow, then carry out
    issue(OP_MOV, 4'd3, 4'd0, 1'b1, 16'h7FFF, WB_ALU); tick();
    issue(OP_ADD, 4'd3, 4'd0, 1'b1, 16'h0001, WB_ALU); tick();
    idle(1);
    rd("ovf_r3", 4'd3, 16'h8000);
    check("ovf_psr", bus.psr_out, 5'h04);
    issue(OP_MOV, 4'd4, 4'd0, 1'b1, 16'hFFFF, WB_ALU); tick();
    issue(OP_ADD, 4'd4, 4'd0, 1'b1, 16'h0001, WB_ALU); tick();
    idle(1);
    rd("cry_r4", 4'd4, 16'h0000);
    check("cry_psr", bus.psr_out, 5'h01);

    // CMP A=r2=5, B=r1=2: N=1 L=1 Z=0, C=1 held, no write
    issue(OP_MOV, 4'd1, 4'd0, 1'b1, 16'd2, WB_ALU); tick();
    issue(OP_MOV, 4'd2, 4'd0, 1'b1, 16'd5, WB_ALU); tick();
    issue(OP_CMP, 4'd2, 4'd1, 1'b0, 16'd0, WB_ALU); tick();
    idle(1);
    check("cmp_wb_valid", bus.wb_valid, 0);
    check("cmp_psr", bus.psr_out, 5'h13);
    rd("cmp_r2", 4'd2, 16'd5);

    // MUL 300*300 with a stray instruction offered while busy
    issue(OP_MOV, 4'd5, 4'd0, 1'b1, 16'd300, WB_ALU); tick();
    idle(2);
    issue(OP_MUL, 4'd5, 4'd0, 1'b1, 16'd300, WB_ALU); tick();
    bus.aluOp = OP_MOV; bus.rDst = 4'd6; bus.imm_sel = 1'b1; bus.imm = 16'h0ABC;
    low_cnt = 0; pulses = 0; first_wb = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!bus.ready_out) low_cnt++;
      if (bus.wb_valid) begin
        pulses++;
        if (first_wb < 0) first_wb = i;
      end
      bus.valid_in = (i < 5);
    end
    bus.valid_in = 1'b0;
    check("mul_ready_low", low_cnt, 16);
    check("mul_pulses", pulses, 1);
    check("mul_latency", first_wb, 17);
    rd("mul_r5", 4'd5, 16'h5F90);
    rd("mul_ignored_r6", 4'd6, 16'h0000);
    check("mul_psr", bus.psr_out, 5'h13);

    // Reset in the middle of a MUL
    @(posedge clk); #1;
    issue(OP_MOV, 4'd7, 4'd0, 1'b1, 16'd9, WB_ALU); tick();
    idle(2);
    issue(OP_MUL, 4'd7, 4'd0, 1'b1, 16'd3, WB_ALU); tick();
    idle(5);
    check("mid_mul_busy", bus.ready_out, 0);
    reset = 1'b1;
    #2;
    check("abort_ready", bus.ready_out, 1);
    check("abort_wb_valid", bus.wb_valid, 0);
    check("abort_psr", bus.psr_out, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.rSrc = 4'(i);
      #1;
      check($sformatf("abort_r%0d", i), bus.dSrc, 16'h0000);
    end
    pulses = 0;
    low_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.wb_valid) pulses++;
      if (!bus.ready_out) low_cnt++;
    end
    check("abort_no_wb", pulses, 0);
    check("abort_no_busy", low_cnt, 0);
    @(posedge clk); #1;

    // Writeback source selection
    bus.pc = 16'h1234;
    issue(OP_ADD, 4'd8, 4'd0, 1'b1, 16'd1, WB_PC); tick();
    idle(1);
    check("pc_wb_valid", bus.wb_valid, 1);
    rd("pc_r8", 4'd8, 16'h1234);
    bus.mem_data = 16'hBEEF;
    issue(OP_MOV, 4'd10, 4'd0, 1'b1, 16'd7, WB_MEM); tick();
    idle(1);
    rd("mem_r10", 4'd10, 16'hBEEF);
    issue(OP_MOV, 4'd9, 4'd0, 1'b1, 16'h0055, WB_NONE); tick();
    idle(1);
    check("none_wb_valid", bus.wb_valid, 0);
    rd("none_r9", 4'd9, 16'h0000);

    // SUB borrow, then LSH left and right (flags hold)
    issue(OP_MOV, 4'd11, 4'd0, 1'b1, 16'd3, WB_ALU); tick();
    issue(OP_SUB, 4'd11, 4'd0, 1'b1, 16'd5, WB_ALU); tick();
    idle(1);
    rd("sub_r11", 4'd11, 16'hFFFE);
    check("sub_psr", bus.psr_out, 5'h01);
    issue(OP_MOV, 4'd12, 4'd0, 1'b1, 16'h0081, WB_ALU); tick();
    issue(OP_LSH, 4'd12, 4'd0, 1'b1, 16'd4, WB_ALU); tick();
    idle(1);
    rd("lsh_l_r12", 4'd12, 16'h0810);
    issue(OP_LSH, 4'd12, 4'd0, 1'b1, 16'hFFFE, WB_ALU); tick();
    idle(1);
    rd("lsh_r_r12", 4'd12, 16'h0204);
    check("lsh_psr", bus.psr_out, 5'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
